// File: rtl/nios2_ocimem_arbiter_pkg.sv
// Shared types and defaults for the OCI debug-RAM arbiter.
package nios2_ocimem_arbiter_pkg;

   // Arbiter sequencing states
   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ACCESS,
      ST_RDATA
   } state_t;

   // JTAG operation waiting for the RAM
   typedef enum logic [1:0] {
      PEND_NONE,
      PEND_RD,
      PEND_WR
   } pend_t;

   // Requester currently holding the RAM
   typedef enum logic {
      OWN_CPU,
      OWN_JTAG
   } owner_t;

   localparam int unsigned JDO_W            = 38;
   localparam int unsigned DATA_W           = 32;
   localparam int unsigned DEF_JDO_ADDR_LSB = 17;
   localparam int unsigned DEF_JDO_DATA_LSB = 3;

endpackage

// File: rtl/nios2_ocimem_jtag_req_latch.sv
// Captures one-cycle JTAG strobes into a single pending op, tracks the JTAG
// address pointer and write buffer, and flags strobes that displace an
// op which never reached the RAM.
module nios2_ocimem_jtag_req_latch
   import nios2_ocimem_arbiter_pkg::*;
#(
   parameter int unsigned ADDR_W       = 8,
   parameter int unsigned JDO_ADDR_LSB = DEF_JDO_ADDR_LSB,
   parameter int unsigned JDO_DATA_LSB = DEF_JDO_DATA_LSB
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [JDO_W-1:0]  jdo,
   input  logic              take_action_ocimem_a,
   input  logic              take_action_ocimem_b,
   input  logic              take_no_action_ocimem_a,
   input  logic              grant,
   input  logic              done,
   output pend_t             pending,
   output logic [ADDR_W-1:0] jtag_addr,
   output logic [DATA_W-1:0] wbuf,
   output logic              jtag_overrun,
   output logic              strobe
);

   pend_t new_op;
   logic  in_service;
   logic  addr_reloaded;
   logic  jdo_unused;

   // jdo also carries fields for other debug ops; reduce it so the whole word stays referenced
   assign jdo_unused = ^jdo;

   // Decode simultaneous strobes: ocimem_a beats ocimem_b beats no_action
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path leaves it unassigned and infers a latch.
      new_op = PEND_NONE;
      strobe = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;
      if (take_action_ocimem_a)         new_op = PEND_RD;
      else if (take_action_ocimem_b)    new_op = PEND_WR;
      else if (take_no_action_ocimem_a) new_op = PEND_RD;
   end

   // Pending op, address pointer, write buffer and overrun flag
   always_ff @(posedge clk) begin
      // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
      if (reset) begin
         pending       <= PEND_NONE;
         jtag_addr     <= '0;
         wbuf          <= '0;
         jtag_overrun  <= 1'b0;
         in_service    <= 1'b0;
         addr_reloaded <= 1'b0;
      end else begin
         // The granted op is already in the RAM registers, so pending only
         // holds ops that are still waiting; a strobe during service is a new op.
         if (strobe)     pending <= new_op;
         else if (grant) pending <= PEND_NONE;

         if (strobe && pending != PEND_NONE && !grant) jtag_overrun <= 1'b1;

         // A fresh address from ocimem_a overrides the post-op increment of the op in flight
         if (take_action_ocimem_a)
            jtag_addr <= jdo[JDO_ADDR_LSB +: ADDR_W];
         else if (done && !addr_reloaded)
            jtag_addr <= jtag_addr + 1'b1;

         if (take_action_ocimem_b && !take_action_ocimem_a)
            wbuf <= jdo[JDO_DATA_LSB +: DATA_W];

         if (grant)     in_service <= 1'b1;
         else if (done) in_service <= 1'b0;

         if (done)                                   addr_reloaded <= 1'b0;
         else if (take_action_ocimem_a && in_service) addr_reloaded <= 1'b1;
      end
   end

endmodule

// File: rtl/nios2_ocimem_arbiter.sv
// Shares the single-port OCI debug RAM between JTAG debug strobes and the
// CPU's Avalon-MM debug slave with round-robin arbitration and fixed
// IDLE -> ACCESS (-> RDATA) sequencing.
module nios2_ocimem_arbiter
   import nios2_ocimem_arbiter_pkg::*;
#(
   parameter int unsigned ADDR_W       = 8,
   parameter int unsigned JDO_ADDR_LSB = DEF_JDO_ADDR_LSB,
   parameter int unsigned JDO_DATA_LSB = DEF_JDO_DATA_LSB
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [JDO_W-1:0]  jdo,
   input  logic              take_action_ocimem_a,
   input  logic              take_action_ocimem_b,
   input  logic              take_no_action_ocimem_a,
   input  logic [ADDR_W-1:0] avs_address,
   input  logic              avs_read,
   input  logic              avs_write,
   input  logic [DATA_W-1:0] avs_writedata,
   output logic              avs_waitrequest,
   output logic [DATA_W-1:0] avs_readdata,
   output logic              avs_readdatavalid,
   output logic [ADDR_W-1:0] ram_addr,
   output logic              ram_we,
   output logic [DATA_W-1:0] ram_wdata,
   input  logic [DATA_W-1:0] ram_rdata,
   output logic [DATA_W-1:0] MonDReg,
   output logic              monitor_ready,
   output logic              jtag_overrun
);

   state_t            state, state_nxt;
   owner_t            owner, last_owner;
   logic              op_write;
   logic              cpu_req, jtag_req;
   logic              grant_cpu, grant_jtag, jtag_done;
   logic              strobe;
   pend_t             pending;
   logic [ADDR_W-1:0] jtag_addr;
   logic [DATA_W-1:0] wbuf;

   nios2_ocimem_jtag_req_latch #(
      .ADDR_W       (ADDR_W),
      .JDO_ADDR_LSB (JDO_ADDR_LSB),
      .JDO_DATA_LSB (JDO_DATA_LSB)
   ) u_req_latch (
      .clk                     (clk),
      .reset                   (reset),
      .jdo                     (jdo),
      .take_action_ocimem_a    (take_action_ocimem_a),
      .take_action_ocimem_b    (take_action_ocimem_b),
      .take_no_action_ocimem_a (take_no_action_ocimem_a),
      .grant                   (grant_jtag),
      .done                    (jtag_done),
      .pending                 (pending),
      .jtag_addr               (jtag_addr),
      .wbuf                    (wbuf),
      .jtag_overrun            (jtag_overrun),
      .strobe                  (strobe)
   );

   assign cpu_req  = avs_read | avs_write;
   assign jtag_req = (pending != PEND_NONE);

   // The CPU command is accepted only in its own ACCESS cycle
   assign avs_waitrequest = !(state == ST_ACCESS && owner == OWN_CPU);

   // Next-state, round-robin grant and completion decode
   always_comb begin
      state_nxt  = state;
      grant_cpu  = 1'b0;
      grant_jtag = 1'b0;
      jtag_done  = 1'b0;
      unique case (state)
         ST_IDLE: begin
            if (jtag_req && (!cpu_req || last_owner == OWN_CPU)) grant_jtag = 1'b1;
            else if (cpu_req)                                    grant_cpu  = 1'b1;
            if (grant_jtag || grant_cpu) state_nxt = ST_ACCESS;
         end
         ST_ACCESS: begin
            if (op_write) begin
               state_nxt = ST_IDLE;
               jtag_done = (owner == OWN_JTAG);
            end else begin
               state_nxt = ST_RDATA;
            end
         end
         ST_RDATA: begin
            state_nxt = ST_IDLE;
            jtag_done = (owner == OWN_JTAG);
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // State register
   always_ff @(posedge clk) begin
      if (reset) state <= ST_IDLE;
      else       state <= state_nxt;
   end

   // RAM command registers, ownership and read-data return paths
   always_ff @(posedge clk) begin
      if (reset) begin
         owner             <= OWN_CPU;
         last_owner        <= OWN_CPU;
         op_write          <= 1'b0;
         ram_addr          <= '0;
         ram_we            <= 1'b0;
         ram_wdata         <= '0;
         avs_readdata      <= '0;
         avs_readdatavalid <= 1'b0;
         MonDReg           <= '0;
         monitor_ready     <= 1'b0;
      end else begin
         ram_we            <= 1'b0;
         avs_readdatavalid <= 1'b0;

         if (grant_jtag) begin
            owner      <= OWN_JTAG;
            last_owner <= OWN_JTAG;
            op_write   <= (pending == PEND_WR);
            ram_we     <= (pending == PEND_WR);
            ram_addr   <= jtag_addr;
            ram_wdata  <= wbuf;
         end else if (grant_cpu) begin
            owner      <= OWN_CPU;
            last_owner <= OWN_CPU;
            op_write   <= avs_write;
            ram_we     <= avs_write;
            ram_addr   <= avs_address;
            ram_wdata  <= avs_writedata;
         end

         if (state == ST_RDATA) begin
            if (owner == OWN_CPU) begin
               avs_readdata      <= ram_rdata;
               avs_readdatavalid <= 1'b1;
            end else begin
               MonDReg <= ram_rdata;
            end
         end

         // A new strobe means the host is waiting on a new op
         if (strobe)         monitor_ready <= 1'b0;
         else if (jtag_done) monitor_ready <= 1'b1;
      end
   end

endmodule
